wb_copy_master: RTL and testbench

Wishbone classic-cycle initiator that copies a block of words from a source address to a destination address on one bus. Software or a control FSM programs source, destination and length, pulses start, and waits for done. It is the master-side counterpart to the team's Wishbone RAM and peripheral responders, used for buffer moves and memory initialisation from a template region.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_copy_master_if.sv | 26 ++
 rtl/wb_copy_master.sv | 159 +++++++++++++++
 tb/tb_wb_copy_master.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: copy-engine state encoding and the
// byte-address to word-index shift helper.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_WRITE = 2'd3
  } copy_state_t;

  // Number of low byte-address bits covered by one bus word.
  function automatic int unsigned byte_to_word_shift(input int unsigned sel_width);
    int unsigned shift;
    shift = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << i) < sel_width) shift = i + 1;
    end
    return shift;
  endfunction

endpackage

// File: rtl/wb_copy_master_if.sv
// Wishbone classic-cycle bus between the copy master and its responder.
interface wb_copy_master_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0]   m_adr_o;
  logic [DATA_WIDTH-1:0]   m_dat_i;
  logic [DATA_WIDTH-1:0]   m_dat_o;
  logic                    m_we_o;
  logic [SELECT_WIDTH-1:0] m_sel_o;
  logic                    m_stb_o;
  logic                    m_ack_i;
  logic                    m_err_i;
  logic                    m_cyc_o;

  modport master (
    output m_adr_o, m_dat_o, m_we_o, m_sel_o, m_stb_o, m_cyc_o,
    input  m_dat_i, m_ack_i, m_err_i
  );

  modport slave (
    input  m_adr_o, m_dat_o, m_we_o, m_sel_o, m_stb_o, m_cyc_o,
    output m_dat_i, m_ack_i, m_err_i
  );
endinterface

// File: rtl/wb_copy_master.sv
// Wishbone block-copy initiator: reads one word from src, writes it to dst,
// repeats for len words; aborts on ERR_I or per-access timeout.
module wb_copy_master
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH    = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  wb_copy_master_if.master      m
);

  localparam int unsigned SHIFT = byte_to_word_shift(SELECT_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(SELECT_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    ~((ADDR_WIDTH'(1) << SHIFT) - ADDR_WIDTH'(1));
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

  copy_state_t           state_q, state_d;
  logic                  next_wr_q, next_wr_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  left_q, left_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;

  logic                    busy_d, done_d, error_d, cyc_d, we_d;
  logic [ADDR_WIDTH-1:0]   adr_d;
  logic [DATA_WIDTH-1:0]   dat_d;
  logic [SELECT_WIDTH-1:0] sel_d;

  logic accept, in_access, ack_ev, err_ev, tmo_ev;

  // A start coinciding with the done pulse is dropped.
  assign accept    = (state_q == ST_IDLE) & start & ~done;
  assign in_access = (state_q == ST_READ) | (state_q == ST_WRITE);
  assign err_ev    = in_access & m.m_err_i;
  assign ack_ev    = in_access & m.m_ack_i & ~m.m_err_i;
  assign tmo_ev    = in_access & (TIMEOUT != 0) & (tmo_q == TMO_LIMIT)
                   & ~m.m_ack_i & ~m.m_err_i;

  // Next state plus the datapath registers that move with it.
  always_comb begin
    state_d   = state_q;
    next_wr_d = next_wr_q;
    src_d     = src_q;
    dst_d     = dst_q;
    left_d    = left_q;
    data_d    = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          src_d  = src_addr & ADDR_MASK;
          dst_d  = dst_addr & ADDR_MASK;
          left_d = len;
          if (len != '0) state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (err_ev) begin
          state_d = ST_IDLE;
        end else if (ack_ev) begin
          data_d    = m.m_dat_i;
          src_d     = src_q + STEP;
          next_wr_d = 1'b1;
          state_d   = ST_PAUSE;
        end else if (tmo_ev) begin
          state_d = ST_IDLE;
        end
      end
      ST_PAUSE: state_d = next_wr_q ? ST_WRITE : ST_READ;
      ST_WRITE: begin
        if (err_ev) begin
          state_d = ST_IDLE;
        end else if (ack_ev) begin
          dst_d     = dst_q + STEP;
          left_d    = left_q - LEN_WIDTH'(1);
          next_wr_d = 1'b0;
          state_d   = (left_q == LEN_WIDTH'(1)) ? ST_IDLE : ST_PAUSE;
        end else if (tmo_ev) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    cyc_d   = (state_d == ST_READ) | (state_d == ST_WRITE);
    we_d    = (state_d == ST_WRITE);
    sel_d   = cyc_d ? '1 : '0;
    adr_d   = '0;
    dat_d   = '0;
    tmo_d   = '0;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (accept & (len == '0)) | (in_access & (state_d == ST_IDLE));
    error_d = error;
    if (state_d == ST_READ)  adr_d = src_d;
    if (state_d == ST_WRITE) begin
      adr_d = dst_d;
      dat_d = data_d;
    end
    // Counter restarts on every access entry and otherwise counts idle waits.
    if (cyc_d && state_d == state_q && TIMEOUT != 0) tmo_d = tmo_q + TMO_W'(1);
    if (accept)                                    error_d = 1'b0;
    if (in_access && (err_ev || tmo_ev))           error_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      next_wr_q <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      left_q    <= '0;
      data_q    <= '0;
      tmo_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      m.m_cyc_o <= 1'b0;
      m.m_stb_o <= 1'b0;
      m.m_we_o  <= 1'b0;
      m.m_sel_o <= '0;
      m.m_adr_o <= '0;
      m.m_dat_o <= '0;
    end else begin
      state_q   <= state_d;
      next_wr_q <= next_wr_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      left_q    <= left_d;
      data_q    <= data_d;
      tmo_q     <= tmo_d;
      busy      <= busy_d;
      done      <= done_d;
      error     <= error_d;
      m.m_cyc_o <= cyc_d;
      m.m_stb_o <= cyc_d;
      m.m_we_o  <= we_d;
      m.m_sel_o <= sel_d;
      m.m_adr_o <= adr_d;
      m.m_dat_o <= dat_d;
    end
  end

endmodule

// File: tb/tb_wb_copy_master.sv
// Bench for wb_copy_master: zero-wait RAM responder with error/mute injection,
// directed corner cases and randomized copies against an array-copy model.
module tb_wb_copy_master;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 4;
  localparam int LW = 16;
  localparam int TMO = 8;
  localparam int WORDS = 16384;
  localparam int BUDGET = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, error;

  wb_copy_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW)) bus ();

  wb_copy_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
    .LEN_WIDTH(LW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .error(error),
    .m(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word-addressed RAM responder: ack one cycle after stb, never twice in a row.
  logic [DW-1:0] mem [WORDS];
  logic [DW-1:0] exp_mem [WORDS];
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wr_log[$];
  int unsigned   wr_cnt = 0;
  int unsigned   err_at = 0;
  bit            mute = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.m_ack_i <= 1'b0;
      bus.m_err_i <= 1'b0;
      bus.m_dat_i <= '0;
    end else begin
      bus.m_ack_i <= 1'b0;
      bus.m_err_i <= 1'b0;
      if (bus.m_cyc_o && bus.m_stb_o && !bus.m_ack_i && !bus.m_err_i && !mute) begin
        if (bus.m_we_o) begin
          wr_cnt = wr_cnt + 1;
          if (wr_cnt == err_at) begin
            bus.m_err_i <= 1'b1;
          end else begin
            bus.m_ack_i <= 1'b1;
            mem[bus.m_adr_o[AW-1:2]] = bus.m_dat_o;
            wr_log.push_back(bus.m_adr_o);
          end
        end else begin
          bus.m_ack_i <= 1'b1;
          bus.m_dat_i <= mem[bus.m_adr_o[AW-1:2]];
          rd_log.push_back(bus.m_adr_o);
        end
      end
    end
  end

  // One copy: start at cycle 0, observe at each negedge until done or budget.
  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [LW-1:0] n, input bit poke, input bit hold_at_done,
                          output int dcyc, output int bcyc, output int scyc,
                          output bit cyc_seen, output bit sel_bad);
    dcyc = 0; bcyc = 0; scyc = 0; cyc_seen = 1'b0; sel_bad = 1'b0;
    rd_log.delete();
    wr_log.delete();
    wr_cnt = 0;
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      if (busy) bcyc++;
      if (bus.m_stb_o) scyc++;
      if (bus.m_cyc_o) begin
        cyc_seen = 1'b1;
        if (bus.m_sel_o !== 4'hF) sel_bad = 1'b1;
      end
      start = poke && (c == 3);
      if (poke && c == 3) begin
        src_addr = s + 16'h0400;
        len = n + 16'd3;
      end
      if (done) begin
        dcyc = c;
        if (hold_at_done) start = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (hold_at_done) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("start_at_done_busy", busy, 0);
      chk("start_at_done_cyc", bus.m_cyc_o, 0);
    end
  endtask

  int dcyc, bcyc, scyc;
  bit cyc_seen, sel_bad;
  int diffs;
  logic [AW-1:0] exp_rd[$];

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_cyc", bus.m_cyc_o, 0);
    chk("rst_stb", bus.m_stb_o, 0);
    chk("rst_we", bus.m_we_o, 0);
    chk("rst_adr", bus.m_adr_o, 0);
    chk("rst_dat", bus.m_dat_o, 0);
    chk("rst_sel", bus.m_sel_o, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed 4-word copy 0x0000 -> 0x0100
    for (int i = 0; i < 4; i++) begin
      mem[i] = 32'h11111111 * (i + 1);
      mem[64 + i] = '0;
    end
    run_copy(16'h0000, 16'h0100, 16'd4, 1'b0, 1'b1, dcyc, bcyc, scyc, cyc_seen, sel_bad);
    chk("dir_done_cycle", dcyc, 24);
    chk("dir_busy_cycles", bcyc, 23);
    chk("dir_error", error, 0);
    chk("dir_sel", sel_bad, 0);
    for (int i = 0; i < 4; i++) chk("dir_word", mem[64 + i], 32'h11111111 * (i + 1));
    chk("dir_rd3_addr", rd_log.size() == 4 ? rd_log[3] : 16'hDEAD, 16'h000C);

    // Zero length
    run_copy(16'h0040, 16'h0080, 16'd0, 1'b0, 1'b0, dcyc, bcyc, scyc, cyc_seen, sel_bad);
    chk("len0_done_cycle", dcyc, 1);
    chk("len0_cyc_seen", cyc_seen, 0);
    chk("len0_busy_cycles", bcyc, 0);

    // Address wrap with unaligned source
    mem[16'h3FFF] = 32'hA5A5_0001;
    mem[0] = 32'hA5A5_0002;
    run_copy(16'hFFFF, 16'h2000, 16'd2, 1'b0, 1'b0, dcyc, bcyc, scyc, cyc_seen, sel_bad);
    chk("wrap_done_cycle", dcyc, 12);
    chk("wrap_nreads", rd_log.size(), 2);
    chk("wrap_rd0", rd_log.size() > 0 ? rd_log[0] : 16'hDEAD, 16'hFFFC);
    chk("wrap_rd1", rd_log.size() > 1 ? rd_log[1] : 16'hDEAD, 16'h0000);
    chk("wrap_w0", mem[16'h0800], 32'hA5A5_0001);
    chk("wrap_w1", mem[16'h0801], 32'hA5A5_0002);

    // Bus error on second write
    for (int i = 0; i < 3; i++) mem[16'h0100 + i] = 32'hDEAD_0000 + i;
    err_at = 2;
    run_copy(16'h0300, 16'h0400, 16'd3, 1'b0, 1'b0, dcyc, bcyc, scyc, cyc_seen, sel_bad);
    chk("err_done_cycle", dcyc, 12);
    chk("err_error", error, 1);
    chk("err_cyc_released", bus.m_cyc_o, 0);
    chk("err_nwrites", wr_log.size(), 1);
    chk("err_w0", mem[16'h0100], mem[16'h00C0]);
    chk("err_w1_untouched", mem[16'h0101], 32'hDEAD_0001);
    err_at = 0;
    run_copy(16'h0300, 16'h0400, 16'd1, 1'b0, 1'b0, dcyc, bcyc, scyc, cyc_seen, sel_bad);
    chk("err_clear_done", dcyc, 6);
    chk("err_cleared", error, 0);

    // Unresponsive slave with a start pulse while busy
    mute = 1'b1;
    run_copy(16'h0500, 16'h0600, 16'd2, 1'b1, 1'b0, dcyc, bcyc, scyc, cyc_seen, sel_bad);
    chk("tmo_done_cycle", dcyc, TMO + 2);
    chk("tmo_stb_cycles", scyc, TMO + 1);
    chk("tmo_error", error, 1);
    mute = 1'b0;
    cyc_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.m_cyc_o || busy) cyc_seen = 1'b1;
    end
    chk("tmo_no_restart", cyc_seen, 0);

    // Reset mid-copy
    @(posedge clk); #1;
    src_addr = 16'h0000; dst_addr = 16'h0700; len = 16'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_cyc", bus.m_cyc_o, 0);
    chk("mrst_stb", bus.m_stb_o, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_error", error, 0);
    @(posedge clk); #1 rst = 1'b0;
    cyc_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.m_cyc_o || busy || done) cyc_seen = 1'b1;
    end
    chk("mrst_quiet", cyc_seen, 0);

    // Randomized copies against a sequential word-copy model
    for (int t = 0; t < 6; t++) begin
      logic [AW-1:0] s, d;
      logic [LW-1:0] n;
      int sw, dw;
      s = AW'($urandom);
      d = AW'($urandom);
      n = LW'($urandom_range(1, 6));
      sw = int'(s >> 2);
      dw = int'(d >> 2);
      exp_mem = mem;
      exp_rd.delete();
      for (int i = 0; i < int'(n); i++) begin
        exp_rd.push_back(AW'(((sw + i) % WORDS) * 4));
        exp_mem[(dw + i) % WORDS] = exp_mem[(sw + i) % WORDS];
      end
      run_copy(s, d, n, 1'b0, 1'b0, dcyc, bcyc, scyc, cyc_seen, sel_bad);
      chk("rnd_done_cycle", dcyc, 6 * int'(n));
      chk("rnd_busy_cycles", bcyc, 6 * int'(n) - 1);
      chk("rnd_error", error, 0);
      diffs = 0;
      for (int i = 0; i < WORDS; i++) if (mem[i] !== exp_mem[i]) diffs++;
      chk("rnd_mem_diffs", diffs, 0);
      diffs = (rd_log.size() == exp_rd.size()) ? 0 : 1;
      for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
        if (rd_log[i] !== exp_rd[i]) diffs++;
      chk("rnd_read_addrs", diffs, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
